// File: rtl/hazard_sched_ctrl_pkg.sv
// Shared definitions for the ID-stage issue scheduler.
//   WB_* : write-back class carried with each ID instruction (2 bits)
//   REG_ADDR_WIDTH : architectural register address width
package hazard_sched_ctrl_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        WB_ALU    = 2'd0,
        WB_LOAD   = 2'd1,
        WB_MULDIV = 2'd2,
        WB_RSVD   = 2'd3   // decoded as ALU
    } wb_class_e;

endpackage

// File: rtl/hazard_sched_ctrl_hz_scoreboard.sv
// Per-register scoreboard of in-flight writes.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   wr_addr_i         : destination register of the issuing instruction
//   ld_set_i          : load issues to wr_addr_i -> counter loads LD_LAT
//   alu_clr_i         : ALU issues to wr_addr_i -> counter cleared
//   md_set_i          : mul/div issues to wr_addr_i -> pending set
//   md_clr_i/_addr_i  : mul/div completion releases its entry
//   rs1/rs2_addr_i    : read ports, *_pend_o = load counter running or mul/div pending
//   rd_addr_i         : read port for WAW, rd_md_pend_o = mul/div pending only
// Entry 0 is never set and always reads as not pending.
module hz_scoreboard
    import hazard_sched_ctrl_pkg::*;
#(
    parameter int unsigned AW     = REG_ADDR_WIDTH,
    parameter int unsigned LD_LAT = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          ld_set_i,
    input  logic          alu_clr_i,
    input  logic          md_set_i,
    input  logic          md_clr_i,
    input  logic [AW-1:0] md_clr_addr_i,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rs1_pend_o,
    output logic          rs2_pend_o,
    output logic          rd_md_pend_o
);

    localparam int unsigned NREG    = 2 ** AW;
    localparam logic [1:0]  LD_INIT = 2'(LD_LAT);

    logic [1:0]      ld_cnt_q [NREG];
    logic [1:0]      ld_cnt_d [NREG];
    logic [NREG-1:0] md_pend_q;
    logic [NREG-1:0] md_pend_d;

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            ld_cnt_d[r]  = ld_cnt_q[r];
            md_pend_d[r] = md_pend_q[r];
            if (r != 0) begin
                // A new load to the same register overrides the running countdown.
                if (ld_set_i && (wr_addr_i == AW'(r)))
                    ld_cnt_d[r] = LD_INIT;
                else if (alu_clr_i && (wr_addr_i == AW'(r)))
                    ld_cnt_d[r] = '0;
                else if (ld_cnt_q[r] != '0)
                    ld_cnt_d[r] = ld_cnt_q[r] - 2'd1;
                // Release first, then set: a completing mul/div followed by a new
                // one to the same register leaves the entry pending.
                if (md_set_i && (wr_addr_i == AW'(r)))
                    md_pend_d[r] = 1'b1;
                else if (md_clr_i && (md_clr_addr_i == AW'(r)))
                    md_pend_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NREG; r++)
                ld_cnt_q[r] <= '0;
            md_pend_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++)
                ld_cnt_q[r] <= ld_cnt_d[r];
            md_pend_q <= md_pend_d;
        end
    end

    assign rs1_pend_o   = (rs1_addr_i != '0) &&
                          ((ld_cnt_q[rs1_addr_i] != '0) || md_pend_q[rs1_addr_i]);
    assign rs2_pend_o   = (rs2_addr_i != '0) &&
                          ((ld_cnt_q[rs2_addr_i] != '0) || md_pend_q[rs2_addr_i]);
    assign rd_md_pend_o = (rd_addr_i != '0) && md_pend_q[rd_addr_i];

endmodule

// File: rtl/hazard_sched_ctrl.sv
// ID-stage issue scheduler for the single-issue RV64 pipeline.
// Stalls only on load-use, mul/div RAW/WAW and mul/div unit busy; ALU
// results are forwarded and never stall.
//   clk, rst                 : clock, asynchronous active-high reset
//   id_valid/id_rs*/id_rd*   : ID-stage instruction fields
//   id_wb_class              : write-back class (see WB_* in the package)
//   ex_flush                 : EX redirect, kills the ID instruction
//   md_done                  : mul/div write-back pulse
//   id_issue                 : ID instruction advances to EX
//   stall_if_id              : hold PC and IF/ID
//   bubble_ex                : insert NOP into ID/EX
//   md_busy                  : a mul/div is outstanding
//   stall_cnt                : saturating count of stall cycles
module hazard_sched_ctrl
    import hazard_sched_ctrl_pkg::*;
#(
    parameter int unsigned AW     = REG_ADDR_WIDTH,
    parameter int unsigned LD_LAT = 2,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1_addr,
    input  logic             id_rs1_used,
    input  logic [AW-1:0]    id_rs2_addr,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    id_rd_addr,
    input  logic             id_rd_wen,
    input  logic [1:0]       id_wb_class,
    input  logic             ex_flush,
    input  logic             md_done,
    output logic             id_issue,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    wb_class_e        cls;
    logic             rs1_pend, rs2_pend, rd_md_pend;
    logic             live, hazard, issue, wr_ok, md_fire;
    logic             md_busy_q, md_busy_d;
    logic [AW-1:0]    md_rd_q, md_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign cls     = wb_class_e'(id_wb_class);
    assign live    = id_valid & ~ex_flush;
    assign md_fire = md_done & md_busy_q;   // stray completions are ignored

    assign hazard = live & (
                        (id_rs1_used & rs1_pend) |
                        (id_rs2_used & rs2_pend) |
                        (id_rd_wen & rd_md_pend) |
                        ((cls == WB_MULDIV) & md_busy_q & ~md_done));

    assign issue = live & ~hazard;
    assign wr_ok = issue & id_rd_wen & (id_rd_addr != '0);

    // Outputs are held low while reset is asserted.
    assign id_issue    = issue & ~rst;
    assign stall_if_id = hazard & ~rst;
    assign bubble_ex   = (hazard | ex_flush | ~id_valid) & ~rst;
    assign md_busy     = md_busy_q;
    assign stall_cnt   = stall_cnt_q;

    hz_scoreboard #(
        .AW     (AW),
        .LD_LAT (LD_LAT)
    ) u_sb (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_addr_i     (id_rd_addr),
        .ld_set_i      (wr_ok & (cls == WB_LOAD)),
        .alu_clr_i     (wr_ok & ((cls == WB_ALU) | (cls == WB_RSVD))),
        .md_set_i      (wr_ok & (cls == WB_MULDIV)),
        .md_clr_i      (md_fire),
        .md_clr_addr_i (md_rd_q),
        .rs1_addr_i    (id_rs1_addr),
        .rs2_addr_i    (id_rs2_addr),
        .rd_addr_i     (id_rd_addr),
        .rs1_pend_o    (rs1_pend),
        .rs2_pend_o    (rs2_pend),
        .rd_md_pend_o  (rd_md_pend)
    );

    always_comb begin
        md_busy_d   = md_busy_q;
        md_rd_d     = md_rd_q;
        stall_cnt_d = stall_cnt_q;
        if (md_fire)
            md_busy_d = 1'b0;
        if (wr_ok && (cls == WB_MULDIV)) begin
            md_busy_d = 1'b1;
            md_rd_d   = id_rd_addr;
        end
        if (hazard && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_busy_q   <= 1'b0;
            md_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_busy_q   <= md_busy_d;
            md_rd_q     <= md_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
module tb_hazard_sched_ctrl;

    localparam int unsigned AW     = 5;
    localparam int unsigned LD_LAT = 2;
    localparam int unsigned CNT_W  = 4;   // small so saturation is reachable

    logic             clk, rst;
    logic             id_valid, id_rs1_used, id_rs2_used, id_rd_wen;
    logic [AW-1:0]    id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [1:0]       id_wb_class;
    logic             ex_flush, md_done;
    logic             id_issue, stall_if_id, bubble_ex, md_busy;
    logic [CNT_W-1:0] stall_cnt;

    hazard_sched_ctrl #(
        .AW     (AW),
        .LD_LAT (LD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1_addr (id_rs1_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_addr (id_rs2_addr),
        .id_rs2_used (id_rs2_used),
        .id_rd_addr  (id_rd_addr),
        .id_rd_wen   (id_rd_wen),
        .id_wb_class (id_wb_class),
        .ex_flush    (ex_flush),
        .md_done     (md_done),
        .id_issue    (id_issue),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             issue;
        logic             stall;
        logic             bubble;
        logic             busy;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // reference model state
    logic [1:0]       m_ld [32];
    logic             m_md [32];
    logic             m_busy;
    logic [4:0]       m_mdrd;
    logic [CNT_W-1:0] m_cnt;

    // last observed outputs (for directed checks)
    logic o_issue, o_stall, o_bubble, o_busy;
    logic [CNT_W-1:0] o_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_ld[i] = 2'd0;
            m_md[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_mdrd = 5'd0;
        m_cnt  = '0;
    endtask

    function automatic logic pend(input logic [4:0] a);
        return (a != 5'd0) && ((m_ld[a] != 2'd0) || m_md[a]);
    endfunction

    // One ID cycle: drive, predict, compare at negedge, advance model.
    task automatic step(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic [1:0] cls, input logic fl,
                        input logic done);
        logic haz, iss;
        exp_t e, got;
        id_valid = v; id_rs1_addr = r1; id_rs1_used = u1;
        id_rs2_addr = r2; id_rs2_used = u2; id_rd_addr = rd;
        id_rd_wen = wen; id_wb_class = cls; ex_flush = fl; md_done = done;

        haz = v && !fl && ((u1 && pend(r1)) || (u2 && pend(r2)) ||
                           (wen && rd != 5'd0 && m_md[rd]) ||
                           (cls == 2'd2 && m_busy && !done));
        iss = v && !fl && !haz;
        e.issue  = iss;
        e.stall  = haz;
        e.bubble = haz || fl || !v;
        e.busy   = m_busy;
        e.cnt    = m_cnt;
        exp_q.push_back(e);

        @(negedge clk);
        got = exp_q.pop_front();
        o_issue = id_issue; o_stall = stall_if_id; o_bubble = bubble_ex;
        o_busy = md_busy; o_cnt = stall_cnt;
        chk("id_issue",    32'(o_issue),  32'(got.issue));
        chk("stall_if_id", 32'(o_stall),  32'(got.stall));
        chk("bubble_ex",   32'(o_bubble), 32'(got.bubble));
        chk("md_busy",     32'(o_busy),   32'(got.busy));
        chk("stall_cnt",   32'(o_cnt),    32'(got.cnt));

        // next state
        for (int i = 1; i < 32; i++)
            if (m_ld[i] != 2'd0) m_ld[i] = m_ld[i] - 2'd1;
        if (done && m_busy) begin
            m_md[m_mdrd] = 1'b0;
            m_busy = 1'b0;
        end
        if (iss && wen && rd != 5'd0) begin
            case (cls)
                2'd1: m_ld[rd] = 2'(LD_LAT);
                2'd2: begin m_md[rd] = 1'b1; m_busy = 1'b1; m_mdrd = rd; end
                default: m_ld[rd] = 2'd0;
            endcase
        end
        if (haz && m_cnt != '1) m_cnt = m_cnt + 1'b1;

        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        chk("rst_issue",  32'(id_issue),    32'd0);
        chk("rst_stall",  32'(stall_if_id), 32'd0);
        chk("rst_bubble", 32'(bubble_ex),   32'd0);
        chk("rst_busy",   32'(md_busy),     32'd0);
        chk("rst_cnt",    32'(stall_cnt),   32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [1:0] ALU = 2'd0, LD = 2'd1, MD = 2'd2;

    initial begin
        rst = 1'b1;
        id_valid = 1'b1; id_rs1_addr = '0; id_rs1_used = 1'b0;
        id_rs2_addr = '0; id_rs2_used = 1'b0; id_rd_addr = 5'd1;
        id_rd_wen = 1'b1; id_wb_class = ALU; ex_flush = 1'b0; md_done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // 1 load-use
        step(1, 0, 0, 0, 0, 5, 1, LD, 0, 0);
        step(1, 5, 1, 0, 0, 6, 1, ALU, 0, 0);
        chk("t1_stall_a", 32'(o_stall), 32'd1);
        step(1, 5, 1, 0, 0, 6, 1, ALU, 0, 0);
        chk("t1_stall_b", 32'(o_stall), 32'd1);
        step(1, 5, 1, 0, 0, 6, 1, ALU, 0, 0);
        chk("t1_issue", 32'(o_issue), 32'd1);
        chk("t1_cnt",   32'(o_cnt),   32'd2);

        // 2 ALU chain
        step(1, 1, 1, 2, 1, 7, 1, ALU, 0, 0);
        chk("t2_issue_a", 32'(o_issue), 32'd1);
        step(1, 7, 1, 7, 1, 8, 1, ALU, 0, 0);
        chk("t2_issue_b",  32'(o_issue),  32'd1);
        chk("t2_bubble_b", 32'(o_bubble), 32'd0);

        // 3 mul/div RAW
        step(1, 1, 1, 2, 1, 9, 1, MD, 0, 0);
        step(1, 0, 0, 9, 1, 10, 1, ALU, 0, 0);
        chk("t3_stall_a", 32'(o_stall), 32'd1);
        step(1, 0, 0, 9, 1, 10, 1, ALU, 0, 0);
        step(1, 0, 0, 9, 1, 10, 1, ALU, 0, 1);
        chk("t3_stall_done", 32'(o_stall), 32'd1);
        chk("t3_busy_done",  32'(o_busy),  32'd1);
        step(1, 0, 0, 9, 1, 10, 1, ALU, 0, 0);
        chk("t3_issue", 32'(o_issue), 32'd1);
        chk("t3_busy",  32'(o_busy),  32'd0);

        // 4 back-to-back mul/div, completion in the second's ID cycle
        step(1, 0, 0, 0, 0, 3, 1, MD, 0, 0);
        step(1, 0, 0, 0, 0, 4, 1, MD, 0, 1);
        chk("t4_issue2", 32'(o_issue), 32'd1);
        step(1, 3, 1, 0, 0, 11, 1, ALU, 0, 0);
        chk("t4_busy",     32'(o_busy),  32'd1);
        chk("t4_x3_free",  32'(o_issue), 32'd1);
        step(1, 4, 1, 0, 0, 11, 1, ALU, 0, 0);
        chk("t4_x4_stall", 32'(o_stall), 32'd1);
        step(1, 4, 1, 0, 0, 11, 1, ALU, 0, 1);
        step(1, 4, 1, 0, 0, 11, 1, ALU, 0, 0);
        chk("t4_x4_issue", 32'(o_issue), 32'd1);

        // 5 x0 and flush
        step(1, 0, 0, 0, 0, 0, 1, LD, 0, 0);
        step(1, 0, 1, 0, 1, 12, 1, ALU, 0, 0);
        chk("t5_x0_issue", 32'(o_issue), 32'd1);
        step(1, 0, 0, 0, 0, 6, 1, LD, 0, 0);
        step(1, 6, 1, 0, 0, 13, 1, ALU, 1, 0);
        chk("t5_fl_issue",  32'(o_issue),  32'd0);
        chk("t5_fl_bubble", 32'(o_bubble), 32'd1);
        chk("t5_fl_stall",  32'(o_stall),  32'd0);
        step(1, 6, 1, 0, 0, 13, 1, ALU, 0, 0);
        chk("t5_after_fl", 32'(o_stall), 32'd1);

        // 6 reset during pending mul/div
        step(1, 0, 0, 0, 0, 9, 1, MD, 0, 0);
        id_rs1_addr = 5'd9; id_rs1_used = 1'b1; id_wb_class = ALU;
        pulse_reset();
        step(1, 9, 1, 0, 0, 14, 1, ALU, 0, 0);
        chk("t6_issue", 32'(o_issue), 32'd1);
        chk("t6_busy",  32'(o_busy),  32'd0);

        // random traffic on a small register window
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) != 0),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        chk("sat_cnt", 32'(stall_cnt), 32'(m_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
